// File: rtl/fifo_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_request_scheduler
//  Brief    : Turns write/readout requests into one-at-a-time we/rd
//             transactions for the master FIFO FSM, with timeout abort.
//  Revision : 1.0
// ============================================================================
module fifo_request_scheduler #(
   parameter int PEND_W  = 4,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic              tx_ready,
   input  logic              read_end,
   input  logic              err_clr,
   output logic              we,
   output logic              rd,
   output logic              abort,
   output logic              busy,
   output logic [PEND_W-1:0] wr_pending,
   output logic              overflow,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_WAIT = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_WAIT = 3'd4
   } state_t;

   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              we_q, we_d, rd_q, rd_d, abort_q, abort_d, busy_q, busy_d;
   logic [PEND_W-1:0] wr_pending_q, wr_pending_d;
   logic              overflow_q, overflow_d, timeout_err_q, timeout_err_d;
   logic              rd_pend_q, rd_pend_d;
   logic              last_rd_q, last_rd_d;
   logic [1:0]        hs_cnt_q, hs_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   logic              w_wr_done, w_to_hit, w_ovf_hit;

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      rd_d      = rd_q;
      abort_d   = 1'b0;
      last_rd_d = last_rd_q;
      hs_cnt_d  = hs_cnt_q;
      to_cnt_d  = to_cnt_q;
      rd_pend_d = rd_pend_q;
      w_wr_done = 1'b0;
      w_to_hit  = 1'b0;

      if (state_q == S_IDLE) begin
         to_cnt_d = '0;
         // Both pending: alternate, reads win when the last grant was a write.
         if (rd_pend_q && (wr_pending_q == '0 || !last_rd_q)) begin
            state_d   = S_RD_REQ;
            rd_d      = 1'b1;
            last_rd_d = 1'b1;
            rd_pend_d = 1'b0;
         end else if (wr_pending_q != '0) begin
            state_d   = S_WR_REQ;
            we_d      = 1'b1;
            last_rd_d = 1'b0;
            hs_cnt_d  = '0;
         end
      end else if (to_cnt_q == TO_LAST) begin
         w_to_hit = 1'b1;
         state_d  = S_IDLE;
         we_d     = 1'b0;
         rd_d     = 1'b0;
         abort_d  = 1'b1;
         hs_cnt_d = '0;
         to_cnt_d = '0;
      end else begin
         to_cnt_d = (tx_ready || read_end) ? '0 : to_cnt_q + 1'b1;
         case (state_q)
            S_WR_REQ: if (tx_ready) begin
               we_d     = 1'b0;
               hs_cnt_d = 2'd1;
               state_d  = S_WR_WAIT;
            end
            S_WR_WAIT: if (tx_ready) begin
               if (hs_cnt_q == 2'd2) begin
                  w_wr_done = 1'b1;
                  hs_cnt_d  = '0;
                  state_d   = S_IDLE;
               end else begin
                  hs_cnt_d = hs_cnt_q + 2'd1;
               end
            end
            S_RD_REQ: if (tx_ready) begin
               rd_d    = 1'b0;
               state_d = S_RD_WAIT;
            end
            S_RD_WAIT: if (read_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // A fresh request in the grant cycle stays queued rather than being lost.
      if (rd_req) rd_pend_d = 1'b1;

      w_ovf_hit    = 1'b0;
      wr_pending_d = wr_pending_q;
      if (wr_req && !w_wr_done) begin
         if (wr_pending_q == PEND_MAX) w_ovf_hit = 1'b1;
         else                          wr_pending_d = wr_pending_q + 1'b1;
      end else if (!wr_req && w_wr_done) begin
         wr_pending_d = wr_pending_q - 1'b1;
      end

      overflow_d    = w_ovf_hit ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
      timeout_err_d = w_to_hit  ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         we_q          <= 1'b0;
         rd_q          <= 1'b0;
         abort_q       <= 1'b0;
         busy_q        <= 1'b0;
         wr_pending_q  <= '0;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         rd_pend_q     <= 1'b0;
         last_rd_q     <= 1'b0;
         hs_cnt_q      <= '0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         rd_q          <= rd_d;
         abort_q       <= abort_d;
         busy_q        <= busy_d;
         wr_pending_q  <= wr_pending_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
         rd_pend_q     <= rd_pend_d;
         last_rd_q     <= last_rd_d;
         hs_cnt_q      <= hs_cnt_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   assign we          = we_q;
   assign rd          = rd_q;
   assign abort       = abort_q;
   assign busy        = busy_q;
   assign wr_pending  = wr_pending_q;
   assign overflow    = overflow_q;
   assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_request_scheduler
//  Brief    : Directed bench with a transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_fifo_request_scheduler;
   localparam int PEND_W  = 4;
   localparam int TIMEOUT = 32;
   localparam int TO_W    = 6;
   localparam int PMAX    = (1 << PEND_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_req = 1'b0, rd_req = 1'b0, tx_ready = 1'b0, read_end = 1'b0, err_clr = 1'b0;
   logic we, rd, abort, busy, overflow, timeout_err;
   logic [PEND_W-1:0] wr_pending;

   int n_chk  = 0;
   int n_fail = 0;

   fifo_request_scheduler #(.PEND_W(PEND_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .tx_ready(tx_ready),
      .read_end(read_end), .err_clr(err_clr), .we(we), .rd(rd), .abort(abort),
      .busy(busy), .wr_pending(wr_pending), .overflow(overflow), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Transaction-level model: kind 0=none 1=write 2=read; req=request phase.
   int m_pend, m_kind, m_hs, m_quiet;
   bit m_rdp, m_last_rd, m_req, m_abort, m_ovf, m_toe;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pend = 0; m_kind = 0; m_hs = 0; m_quiet = 0;
         m_rdp = 0; m_last_rd = 0; m_req = 0; m_abort = 0; m_ovf = 0; m_toe = 0;
      end else begin : model_step
         bit done, tmo, ovf_ev;
         done = 0; tmo = 0; ovf_ev = 0; m_abort = 0;
         if (m_kind == 0) begin
            if (m_rdp && (m_pend == 0 || !m_last_rd)) begin
               m_kind = 2; m_req = 1; m_last_rd = 1; m_rdp = 0; m_quiet = 0;
            end else if (m_pend > 0) begin
               m_kind = 1; m_req = 1; m_last_rd = 0; m_quiet = 0; m_hs = 0;
            end
         end else if (m_quiet == TIMEOUT - 1) begin
            m_kind = 0; m_req = 0; m_abort = 1; tmo = 1;
         end else begin
            m_quiet = (tx_ready || read_end) ? 0 : m_quiet + 1;
            if (m_kind == 1 && tx_ready) begin
               m_hs++;
               m_req = 0;
               if (m_hs == 3) begin done = 1; m_kind = 0; end
            end else if (m_kind == 2) begin
               if (m_req && tx_ready) m_req = 0;
               else if (!m_req && read_end) m_kind = 0;
            end
         end
         if (rd_req) m_rdp = 1;
         if (wr_req && !done) begin
            if (m_pend == PMAX) ovf_ev = 1;
            else m_pend++;
         end else if (!wr_req && done) m_pend--;
         m_ovf = ovf_ev ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
         m_toe = tmo ? 1'b1 : (err_clr ? 1'b0 : m_toe);
      end
   end

   always @(negedge clk) begin : cmp
      logic [PEND_W+5:0] act, exp;
      act = {we, rd, abort, busy, wr_pending, overflow, timeout_err};
      exp = {(m_kind == 1 && m_req), (m_kind == 2 && m_req), m_abort, (m_kind != 0),
             PEND_W'(m_pend), m_ovf, m_toe};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cycle_cmp t=%0t {we,rd,abort,busy,pend,ovf,toe} got=%b want=%b",
                  $time, act, exp);
      end
   end

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit w, input bit r, input bit t, input bit e, input bit c);
      wr_req = w; rd_req = r; tx_ready = t; read_end = e; err_clr = c;
      @(negedge clk);
      wr_req = 0; rd_req = 0; tx_ready = 0; read_end = 0; err_clr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic finish_write();
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
   endtask

   initial begin
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      lit("reset_we", we, 0);
      lit("reset_busy", busy, 0);
      lit("reset_pend", wr_pending, 0);
      rst = 1'b1;

      // three writes queued, then drained with three handshakes each
      step(1, 0, 0, 0, 0);
      lit("t1_pend1", wr_pending, 1);
      lit("t1_we_before_grant", we, 0);
      step(0, 0, 0, 0, 0);
      lit("t1_we_granted", we, 1);
      step(1, 0, 0, 0, 0);
      lit("t1_pend2", wr_pending, 2);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      lit("t1_pend3", wr_pending, 3);
      step(0, 0, 1, 0, 0);
      lit("t1_we_drop", we, 0);
      lit("t1_busy_wait", busy, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      lit("t1_pend_after1", wr_pending, 2);
      lit("t1_busy_idle", busy, 0);
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 0, 0);
         lit("t1_regrant", we, 1);
         finish_write();
      end
      idle(2);
      lit("t1_pend_end", wr_pending, 0);
      lit("t1_busy_end", busy, 0);

      // simultaneous write and read from reset: read first
      do_reset();
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      lit("t2_rd_first", rd, 1);
      lit("t2_we_not", we, 0);
      step(0, 0, 1, 0, 0);
      lit("t2_rd_drop", rd, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      lit("t2_idle", busy, 0);
      step(0, 0, 0, 0, 0);
      lit("t2_we_next", we, 1);
      finish_write();
      idle(2);

      // saturation and overflow clearing
      do_reset();
      for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 0);
      lit("t3_pend_sat", wr_pending, 15);
      lit("t3_ovf", overflow, 1);
      step(0, 0, 0, 0, 1);
      lit("t3_ovf_clr", overflow, 0);
      lit("t3_pend_kept", wr_pending, 15);
      idle(2);

      // timeout abort and retry
      do_reset();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      idle(TIMEOUT - 1);
      lit("t4_no_abort_yet", abort, 0);
      lit("t4_still_busy", busy, 1);
      step(0, 0, 0, 0, 0);
      lit("t4_abort", abort, 1);
      lit("t4_toe", timeout_err, 1);
      lit("t4_busy0", busy, 0);
      lit("t4_pend_kept", wr_pending, 1);
      step(0, 0, 0, 0, 0);
      lit("t4_abort_pulse", abort, 0);
      lit("t4_we_retry", we, 1);
      finish_write();
      step(0, 0, 0, 0, 1);
      lit("t4_toe_clr", timeout_err, 0);
      lit("t4_pend0", wr_pending, 0);

      // wr_req coincident with completing handshake
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      lit("t5_we", we, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      lit("t5_pend_same", wr_pending, 2);
      step(0, 0, 0, 0, 0);
      finish_write();
      step(0, 0, 0, 0, 0);
      finish_write();
      idle(2);
      lit("t5_pend0", wr_pending, 0);

      // asynchronous reset in RD_WAIT
      do_reset();
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      lit("t6_rd", rd, 1);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      lit("t6_busy_pre", busy, 1);
      #2 rst = 1'b0;
      #1;
      lit("t6_rd_async", rd, 0);
      lit("t6_busy_async", busy, 0);
      lit("t6_pend_async", wr_pending, 0);
      lit("t6_rdpend_async", dut.rd_pend_q, 0);
      @(negedge clk);
      rst = 1'b1;
      idle(4);
      lit("t6_no_grant_busy", busy, 0);
      lit("t6_no_grant_rd", rd, 0);
      lit("t6_no_grant_we", we, 0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
